// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer.
// Collects WIDTH serial bits (MSB first) qualified by sin_en, assembles them
// into a word and presents it on a valid/ready holding register. A word that
// completes while the holding register is still occupied is dropped and
// raises the sticky overrun flag.
// Optional feature macro: PARITY_EN. When defined, every frame carries one
// trailing even-parity bit that is checked in the PAR state; mismatches set
// the sticky parity_err flag. When undefined, parity_err is tied to 0.
module sipo_deser #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             abort,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

`ifdef PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } state_t;
`endif

   // Count value held while the last data bit of a word is being sampled.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [WIDTH-1:0]  shift_q, shift_d;
   logic [WIDTH-1:0]         dout_q, dout_d;
   logic                     dout_valid_q, dout_valid_d;
   logic                     overrun_q, overrun_d;

   // Word-completion strobe from the framing FSM and the word it carries.
   logic                     word_done;
   logic [WIDTH-1:0]         word_val;
   logic [WIDTH-1:0]         shift_in;
   logic                     hold_free;

`ifdef PARITY_EN
   logic                     parity_err_q, parity_err_d;
   logic                     par_bad;
`endif

   // Current shift contents with the incoming serial bit appended at the LSB,
   // so the first bit received ends up in the MSB after WIDTH shifts.
   assign shift_in = {shift_q[WIDTH-2:0], sin};

   // Framing FSM: bit capture, bit counting, abort handling, completion strobe.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      word_done = 1'b0;
      word_val  = shift_in;
`ifdef PARITY_EN
      par_bad   = 1'b0;
`endif
      if (abort) begin
         // abort wins over any bit sampled this cycle, including a final bit.
         state_d = IDLE;
         cnt_d   = '0;
      end else if (sin_en) begin
         case (state_q)
            IDLE: begin
               shift_d = shift_in;
               cnt_d   = ONE_CNT;
               state_d = SHIFT;
            end
            SHIFT: begin
               shift_d = shift_in;
               if (cnt_q == LAST_CNT) begin
                  cnt_d = '0;
`ifdef PARITY_EN
                  // Data complete; the frame still owes its parity bit.
                  state_d = PAR;
`else
                  state_d   = IDLE;
                  word_done = 1'b1;
                  word_val  = shift_in;
`endif
               end else begin
                  cnt_d = cnt_q + ONE_CNT;
               end
            end
`ifdef PARITY_EN
            PAR: begin
               // Even parity: data bits plus parity bit must XOR to zero.
               state_d   = IDLE;
               word_done = 1'b1;
               word_val  = shift_q;
               par_bad   = ^{shift_q, sin};
            end
`endif
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // The holding register can take a new word if it is empty or is being
   // emptied by the consumer on this very edge.
   assign hold_free = ~dout_valid_q | dout_ready;

   // Holding register, handshake and sticky error flags.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = overrun_q;
`ifdef PARITY_EN
      parity_err_d = parity_err_q;
`endif
      if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
      if (word_done) begin
         if (hold_free) begin
            dout_d       = word_val;
            dout_valid_d = 1'b1;
         end else begin
            // Consumer stalled: keep the older word, drop the new one.
            overrun_d = 1'b1;
         end
`ifdef PARITY_EN
         if (par_bad) begin
            parity_err_d = 1'b1;
         end
`endif
      end
   end

   // State, counter and data registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
      end
   end

`ifdef PARITY_EN
   // Sticky parity error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != IDLE);

endmodule
